// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared state encoding and counter widths for the PLL bring-up controller
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PWD       = 3'd0,
    ST_RST       = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_FILTER    = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } pll_state_e;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  // Bits needed for a counter that must hold max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_ctrl_if.sv
// rtl/pll_ctrl_if.sv - PLL control, channel reset and status signals of the bring-up controller
interface pll_ctrl_if
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4
) ();

  logic                pll_lock;
  logic                restart;
  logic                pll_pwd;
  logic                pll_rst;
  logic                rstodiv;
  logic [NUM_CH-1:0]   ch_rst_n;
  logic                ready;
  logic                fail;
  logic [2:0]          state;
  logic [RETRY_W-1:0]  retry_cnt;
  logic [LOSS_W-1:0]   lock_loss_cnt;

  modport master (
    input  pll_lock, restart,
    output pll_pwd, pll_rst, rstodiv, ch_rst_n, ready, fail, state, retry_cnt, lock_loss_cnt
  );

  modport slave (
    output pll_lock, restart,
    input  pll_pwd, pll_rst, rstodiv, ch_rst_n, ready, fail, state, retry_cnt, lock_loss_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level, resets to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_ctrl.sv
// rtl/pll_ctrl.sv - PLL power-up, lock filtering, retry and staggered channel release controller
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 256,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int STAGGER      = 64,
  parameter int MAX_RETRY    = 7
) (
  input  logic       clkin1,
  input  logic       rst_n,
  pll_ctrl_if.master pll
);

  localparam int REL_LAST   = (NUM_CH - 1) * STAGGER;
  localparam int DWELL_MAX0 = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES - 1 : LOCK_FILTER - 1;
  localparam int DWELL_MAX  = (DWELL_MAX0 > REL_LAST) ? DWELL_MAX0 : REL_LAST;
  localparam int DW         = cnt_width(DWELL_MAX);
  localparam int TW         = cnt_width(LOCK_TIMEOUT);

  pll_state_e          state_q;
  logic [DW-1:0]       dwell_q;
  logic [TW-1:0]       tmo_q;
  logic [RETRY_W-1:0]  retry_q;
  logic [LOSS_W-1:0]   loss_q;
  logic                pwd_q;
  logic                prst_q;
  logic                odiv_q;
  logic [NUM_CH-1:0]   ch_q;
  logic                ready_q;
  logic                fail_q;
  logic                lock_s;
  logic [RETRY_W-1:0]  retry_next;
  logic [LOSS_W-1:0]   loss_next;
  logic                hit_max;

  sync_2ff u_lock_sync (
    .clk   (clkin1),
    .rst_n (rst_n),
    .d     (pll.pll_lock),
    .q     (lock_s)
  );

  assign retry_next = (&retry_q) ? retry_q : retry_q + 1'b1;
  assign loss_next  = (&loss_q) ? loss_q : loss_q + 1'b1;
  assign hit_max    = (MAX_RETRY != 0) && (32'(retry_next) >= 32'(MAX_RETRY));

  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWD;
      dwell_q <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
      pwd_q   <= 1'b1;
      prst_q  <= 1'b1;
      odiv_q  <= 1'b1;
      ch_q    <= '0;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else if (pll.restart) begin
      // Restart overrides everything but keeps the lock-loss history.
      state_q <= ST_PWD;
      dwell_q <= '0;
      retry_q <= '0;
      pwd_q   <= 1'b1;
      prst_q  <= 1'b1;
      odiv_q  <= 1'b1;
      ch_q    <= '0;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_PWD: begin
          if (dwell_q == DW'(RST_CYCLES - 1)) begin
            state_q <= ST_RST;
            dwell_q <= '0;
            tmo_q   <= '0;
            pwd_q   <= 1'b0;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        ST_RST: begin
          if (dwell_q == DW'(RST_CYCLES - 1)) begin
            state_q <= ST_WAIT_LOCK;
            dwell_q <= '0;
            prst_q  <= 1'b0;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= ST_FILTER;
            dwell_q <= '0;
          end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
            retry_q <= retry_next;
            dwell_q <= '0;
            pwd_q   <= 1'b1;
            prst_q  <= 1'b1;
            if (hit_max) begin
              state_q <= ST_FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q <= ST_PWD;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_FILTER: begin
          // A dropout restarts the filter but the lock-wait budget keeps running.
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
            dwell_q <= '0;
          end else if (dwell_q == DW'(LOCK_FILTER - 1)) begin
            state_q <= ST_RELEASE;
            dwell_q <= '0;
            odiv_q  <= 1'b0;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!lock_s) begin
            state_q <= ST_RST;
            dwell_q <= '0;
            tmo_q   <= '0;
            pwd_q   <= 1'b0;
            prst_q  <= 1'b1;
            odiv_q  <= 1'b1;
            ch_q    <= '0;
            ready_q <= 1'b0;
            loss_q  <= loss_next;
          end else if (state_q == ST_RELEASE) begin
            // Channel i comes out of reset one cycle after the dwell reaches i*STAGGER.
            for (int i = 0; i < NUM_CH; i++) begin
              if (dwell_q == DW'(i * STAGGER)) ch_q[i] <= 1'b1;
            end
            if (dwell_q == DW'(REL_LAST)) begin
              state_q <= ST_RUN;
              ch_q    <= '1;
              ready_q <= 1'b1;
              retry_q <= '0;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
        end
        ST_FAIL: begin
          state_q <= ST_FAIL;
        end
        default: begin
          state_q <= ST_PWD;
          dwell_q <= '0;
          pwd_q   <= 1'b1;
          prst_q  <= 1'b1;
          odiv_q  <= 1'b1;
          ch_q    <= '0;
          ready_q <= 1'b0;
          fail_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pll.state         = state_q;
  assign pll.pll_pwd       = pwd_q;
  assign pll.pll_rst       = prst_q;
  assign pll.rstodiv       = odiv_q;
  assign pll.ch_rst_n      = ch_q;
  assign pll.ready         = ready_q;
  assign pll.fail          = fail_q;
  assign pll.retry_cnt     = retry_q;
  assign pll.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// tb/tb_pll_ctrl.sv - scoreboard bench for pll_ctrl: default-parameter DUT A, short-parameter DUT B
module tb_pll_ctrl;

  localparam int S_STATE = 0, S_READY = 1, S_CH = 2, S_ODIV = 3, S_PWD = 4;
  localparam int S_RST = 5, S_RETRY = 6, S_LOSS = 7, S_FAIL = 8, B = 16;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t q[$];

  string names[9] = '{"state", "ready", "ch_rst_n", "rstodiv", "pll_pwd", "pll_rst",
                      "retry_cnt", "lock_loss_cnt", "fail"};

  pll_ctrl_if #(.NUM_CH(4)) a_if ();
  pll_ctrl_if #(.NUM_CH(4)) b_if ();

  pll_ctrl dut_a (
    .clkin1 (clk),
    .rst_n  (rst_n_a),
    .pll    (a_if)
  );

  pll_ctrl #(
    .NUM_CH       (4),
    .RST_CYCLES   (2),
    .LOCK_FILTER  (4),
    .LOCK_TIMEOUT (100),
    .STAGGER      (2),
    .MAX_RETRY    (3)
  ) dut_b (
    .clkin1 (clk),
    .rst_n  (rst_n_b),
    .pll    (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_STATE:     return 32'(a_if.state);
      S_READY:     return 32'(a_if.ready);
      S_CH:        return 32'(a_if.ch_rst_n);
      S_ODIV:      return 32'(a_if.rstodiv);
      S_PWD:       return 32'(a_if.pll_pwd);
      S_RST:       return 32'(a_if.pll_rst);
      S_RETRY:     return 32'(a_if.retry_cnt);
      S_LOSS:      return 32'(a_if.lock_loss_cnt);
      S_FAIL:      return 32'(a_if.fail);
      B + S_STATE: return 32'(b_if.state);
      B + S_READY: return 32'(b_if.ready);
      B + S_CH:    return 32'(b_if.ch_rst_n);
      B + S_ODIV:  return 32'(b_if.rstodiv);
      B + S_PWD:   return 32'(b_if.pll_pwd);
      B + S_RST:   return 32'(b_if.pll_rst);
      B + S_RETRY: return 32'(b_if.retry_cnt);
      B + S_LOSS:  return 32'(b_if.lock_loss_cnt);
      B + S_FAIL:  return 32'(b_if.fail);
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = probe(e.sel);
      n_tests = n_tests + 1;
      if (e.cyc != cyc || act !== e.exp) begin
        n_fail = n_fail + 1;
        $display("FAIL %s.%s @cyc %0d (checked at %0d): got %0h, expected %0h",
                 (e.sel >= B) ? "B" : "A", names[e.sel % B], e.cyc, cyc, act, e.exp);
      end
    end
  end

  function automatic void push(input int c, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.exp = v;
    q.push_back(e);
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_b(input int st, input int lim);
    int n;
    n = 0;
    while (int'(b_if.state) != st && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_tests = n_tests + 1;
    if (int'(b_if.state) != st) begin
      n_fail = n_fail + 1;
      $display("FAIL B wait for state %0d expired after %0d cycles @cyc %0d (state %0d)",
               st, lim, cyc, b_if.state);
    end
    push(cyc, B + S_STATE, st);
  endtask

  int t0;
  int tb0;

  initial begin
    cyc = 0;
    n_tests = 0;
    n_fail = 0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    a_if.pll_lock = 1'b1;
    a_if.restart  = 1'b0;
    b_if.pll_lock = 1'b0;
    b_if.restart  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    n_tests = n_tests + 1;
    if (a_if.state !== 3'd0 || a_if.pll_pwd !== 1'b1 || a_if.pll_rst !== 1'b1 ||
        a_if.rstodiv !== 1'b1 || a_if.ch_rst_n !== 4'h0 || a_if.ready !== 1'b0 ||
        b_if.fail !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset state @cyc %0d: state %0h pwd %0b rst %0b odiv %0b ch %0h ready %0b fail_b %0b",
               cyc, a_if.state, a_if.pll_pwd, a_if.pll_rst, a_if.rstodiv, a_if.ch_rst_n,
               a_if.ready, b_if.fail);
    end
    push(cyc, S_STATE, 0); push(cyc, S_PWD, 1); push(cyc, S_RST, 1); push(cyc, S_ODIV, 1);
    push(cyc, S_CH, 0); push(cyc, S_READY, 0); push(cyc, B + S_FAIL, 0);

    // DUT A: bring-up timeline, lock drop, restart, filter glitch, mid-release reset.
    @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    t0 = cyc;
    push(t0, S_STATE, 0); push(t0, S_RETRY, 0); push(t0, S_LOSS, 0); push(t0, S_FAIL, 0);
    push(t0 + 15, S_STATE, 0);
    push(t0 + 16, S_STATE, 1); push(t0 + 16, S_PWD, 0); push(t0 + 16, S_RST, 1);
    push(t0 + 31, S_STATE, 1);
    push(t0 + 32, S_STATE, 2); push(t0 + 32, S_RST, 0);
    push(t0 + 33, S_STATE, 3); push(t0 + 33, S_ODIV, 1);
    push(t0 + 288, S_STATE, 3); push(t0 + 288, S_ODIV, 1);
    push(t0 + 289, S_STATE, 4); push(t0 + 289, S_ODIV, 0); push(t0 + 289, S_CH, 4'h0);
    push(t0 + 290, S_CH, 4'h1); push(t0 + 353, S_CH, 4'h1); push(t0 + 354, S_CH, 4'h3);
    push(t0 + 417, S_CH, 4'h3); push(t0 + 418, S_CH, 4'h7);
    push(t0 + 481, S_CH, 4'h7); push(t0 + 481, S_READY, 0); push(t0 + 481, S_STATE, 4);
    push(t0 + 482, S_CH, 4'hF); push(t0 + 482, S_READY, 1); push(t0 + 482, S_STATE, 5);
    push(t0 + 482, S_RETRY, 0);
    push(t0 + 502, S_STATE, 5); push(t0 + 502, S_READY, 1); push(t0 + 502, S_LOSS, 0);
    push(t0 + 503, S_STATE, 1); push(t0 + 503, S_CH, 0); push(t0 + 503, S_READY, 0);
    push(t0 + 503, S_ODIV, 1); push(t0 + 503, S_LOSS, 1);
    push(t0 + 968, S_READY, 0); push(t0 + 968, S_STATE, 4);
    push(t0 + 969, S_READY, 1); push(t0 + 969, S_CH, 4'hF); push(t0 + 969, S_STATE, 5);
    push(t0 + 1000, S_STATE, 5);
    push(t0 + 1001, S_STATE, 0); push(t0 + 1001, S_READY, 0); push(t0 + 1001, S_CH, 0);
    push(t0 + 1001, S_PWD, 1); push(t0 + 1001, S_RST, 1); push(t0 + 1001, S_ODIV, 1);
    push(t0 + 1001, S_LOSS, 1); push(t0 + 1001, S_RETRY, 0);
    push(t0 + 1234, S_STATE, 3); push(t0 + 1235, S_STATE, 2); push(t0 + 1235, S_RETRY, 0);
    push(t0 + 1236, S_STATE, 3); push(t0 + 1491, S_STATE, 3);
    push(t0 + 1492, S_STATE, 4); push(t0 + 1492, S_ODIV, 0);
    push(t0 + 1599, S_CH, 4'h3); push(t0 + 1599, S_STATE, 4);
    push(t0 + 1600, S_STATE, 0); push(t0 + 1600, S_CH, 0); push(t0 + 1600, S_READY, 0);
    push(t0 + 1600, S_ODIV, 1); push(t0 + 1600, S_PWD, 1); push(t0 + 1600, S_RST, 1);
    push(t0 + 1600, S_LOSS, 0); push(t0 + 1600, S_RETRY, 0);
    push(t0 + 1894, S_STATE, 4); push(t0 + 1894, S_ODIV, 0); push(t0 + 1895, S_CH, 4'h1);
    push(t0 + 2087, S_READY, 1); push(t0 + 2087, S_CH, 4'hF);

    wait_cyc(t0 + 500);  a_if.pll_lock = 1'b0;
    wait_cyc(t0 + 501);  a_if.pll_lock = 1'b1;
    wait_cyc(t0 + 1000); a_if.restart = 1'b1;
    wait_cyc(t0 + 1001); a_if.restart = 1'b0;
    wait_cyc(t0 + 1232); a_if.pll_lock = 1'b0;
    wait_cyc(t0 + 1233); a_if.pll_lock = 1'b1;
    wait_cyc(t0 + 1600); rst_n_a = 1'b0;
    wait_cyc(t0 + 1605); rst_n_a = 1'b1;
    wait_cyc(t0 + 2090);

    // DUT B: lock never arrives, three timeouts then FAIL, restart, then lock-loss saturation.
    rst_n_b = 1'b1;
    tb0 = cyc;
    push(tb0, B + S_STATE, 0); push(tb0, B + S_PWD, 1); push(tb0, B + S_RETRY, 0);
    push(tb0 + 3, B + S_STATE, 1);
    push(tb0 + 4, B + S_STATE, 2); push(tb0 + 4, B + S_RST, 0);
    push(tb0 + 103, B + S_STATE, 2); push(tb0 + 103, B + S_RETRY, 0);
    push(tb0 + 104, B + S_STATE, 0); push(tb0 + 104, B + S_RETRY, 1);
    push(tb0 + 104, B + S_PWD, 1); push(tb0 + 104, B + S_RST, 1);
    push(tb0 + 207, B + S_STATE, 2); push(tb0 + 207, B + S_RETRY, 1);
    push(tb0 + 208, B + S_STATE, 0); push(tb0 + 208, B + S_RETRY, 2);
    push(tb0 + 311, B + S_STATE, 2);
    push(tb0 + 312, B + S_STATE, 6); push(tb0 + 312, B + S_FAIL, 1);
    push(tb0 + 312, B + S_RETRY, 3); push(tb0 + 312, B + S_PWD, 1);
    push(tb0 + 312, B + S_RST, 1); push(tb0 + 312, B + S_CH, 0); push(tb0 + 312, B + S_READY, 0);
    push(tb0 + 320, B + S_STATE, 6);
    push(tb0 + 322, B + S_STATE, 0); push(tb0 + 322, B + S_RETRY, 0); push(tb0 + 322, B + S_FAIL, 0);
    push(tb0 + 337, B + S_STATE, 4); push(tb0 + 337, B + S_CH, 4'h7);
    push(tb0 + 338, B + S_STATE, 5); push(tb0 + 338, B + S_READY, 1); push(tb0 + 338, B + S_CH, 4'hF);

    wait_cyc(tb0 + 321); b_if.restart = 1'b1;
    wait_cyc(tb0 + 322); b_if.restart = 1'b0; b_if.pll_lock = 1'b1;
    wait_cyc(tb0 + 340);

    for (int i = 1; i <= 300; i++) begin
      if (i > 1) wait_b(4, 60);
      b_if.pll_lock = 1'b0;
      @(posedge clk);
      #1;
      b_if.pll_lock = 1'b1;
      wait_b(1, 20);
      push(cyc, B + S_LOSS, (i < 255) ? i : 255);
    end

    b_if.restart = 1'b1;
    push(cyc + 1, B + S_STATE, 0); push(cyc + 1, B + S_LOSS, 255); push(cyc + 1, B + S_RETRY, 0);
    wait_cyc(cyc + 1);
    b_if.restart = 1'b0;
    wait_cyc(cyc + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
